mem_arbiter: RTL and testbench

Shares the core's single memory port between the instruction fetch unit and the load/store unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, keeps one transaction in flight at a time, and returns each response to the requester that issued it. It sits between `ifu`/`lsu` and the memory/DPI bridge, replacing the per-unit direct memory access paths.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 64;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; keeps the last-served requester.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,    // [0]=IFU, [1]=LSU
  input  logic       i_upd,    // a grant was accepted this cycle
  output logic [1:0] o_grant   // one-hot
);

  owner_e r_last;

  // Single requester wins outright; on a tie the one not served last wins.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_last == OWN_IFU) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  // Remember who was served on each accepted grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= OWN_IFU;
    end else if (i_upd) begin
      r_last <= o_grant[1] ? OWN_LSU : OWN_IFU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                ifu_req_valid_i,
  output logic                ifu_req_ready_o,
  input  logic [ADDR_W-1:0]   ifu_req_addr_i,
  output logic                ifu_rsp_valid_o,
  input  logic                ifu_rsp_ready_i,
  output logic [DATA_W-1:0]   ifu_rsp_data_o,
  output logic                ifu_rsp_err_o,

  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_req_addr_i,
  input  logic                lsu_req_wen_i,
  input  logic [DATA_W-1:0]   lsu_req_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_req_wmask_i,
  output logic                lsu_rsp_valid_o,
  input  logic                lsu_rsp_ready_i,
  output logic [DATA_W-1:0]   lsu_rsp_data_o,
  output logic                lsu_rsp_err_o,

  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic                mem_req_wen_o,
  output logic [DATA_W-1:0]   mem_req_wdata_o,
  output logic [DATA_W/8-1:0] mem_req_wmask_o,
  input  logic                mem_rsp_valid_i,
  output logic                mem_rsp_ready_o,
  input  logic [DATA_W-1:0]   mem_rsp_data_i
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e              r_state;
  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_req_valid;
  logic                r_ifu_rsp_valid;
  logic                r_lsu_rsp_valid;

  logic                w_idle;
  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic                w_rsp_hs;

  // Requests are only offered to the arbiter while idle and out of reset.
  assign w_idle = (r_state == IDLE) && !rst_i;
  assign w_req  = {lsu_req_valid_i, ifu_req_valid_i} & {2{w_idle}};

  rr_arb2 u_rr_arb2 (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_req   (w_req),
    .i_upd   (|w_grant),
    .o_grant (w_grant)
  );

  assign w_rsp_hs = (r_owner == OWN_IFU) ? ifu_rsp_ready_i : lsu_rsp_ready_i;

  // Transaction FSM with latched request, response and timeout counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_owner         <= OWN_IFU;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wdata         <= '0;
      r_wmask         <= '0;
      r_rsp_data      <= '0;
      r_rsp_err       <= 1'b0;
      r_cnt           <= '0;
      r_mem_req_valid <= 1'b0;
      r_ifu_rsp_valid <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant[1]) begin
            r_owner         <= OWN_LSU;
            r_addr          <= lsu_req_addr_i;
            r_wen           <= lsu_req_wen_i;
            r_wdata         <= lsu_req_wdata_i;
            r_wmask         <= lsu_req_wmask_i;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end else if (w_grant[0]) begin
            r_owner         <= OWN_IFU;
            r_addr          <= ifu_req_addr_i;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid_i || (r_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
            r_rsp_data <= mem_rsp_valid_i ? mem_rsp_data_i : '0;
            r_rsp_err  <= !mem_rsp_valid_i;
            r_ifu_rsp_valid <= (r_owner == OWN_IFU);
            r_lsu_rsp_valid <= (r_owner == OWN_LSU);
            r_state    <= RSP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RSP: begin
          if (w_rsp_hs) begin
            r_ifu_rsp_valid <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode; memory responses are always accepted (stray ones dropped).
  assign ifu_req_ready_o = w_grant[0];
  assign lsu_req_ready_o = w_grant[1];
  assign ifu_rsp_valid_o = r_ifu_rsp_valid;
  assign lsu_rsp_valid_o = r_lsu_rsp_valid;
  assign ifu_rsp_data_o  = r_rsp_data;
  assign lsu_rsp_data_o  = r_rsp_data;
  assign ifu_rsp_err_o   = r_rsp_err;
  assign lsu_rsp_err_o   = r_rsp_err;
  assign mem_req_valid_o = r_mem_req_valid;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_wen_o   = r_wen;
  assign mem_req_wdata_o = r_wdata;
  assign mem_req_wmask_o = r_wmask;
  assign mem_rsp_ready_o = 1'b1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT_CYC=4).
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_rsp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_rsp_data;
  logic [MW-1:0] lsu_req_wmask;
  logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_rsp_data;
  logic [MW-1:0] mem_req_wmask;

  int n_pass = 0;
  int n_total = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready), .ifu_req_addr_i(ifu_req_addr),
    .ifu_rsp_valid_o(ifu_rsp_valid), .ifu_rsp_ready_i(ifu_rsp_ready), .ifu_rsp_data_o(ifu_rsp_data),
    .ifu_rsp_err_o(ifu_rsp_err),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready), .lsu_req_addr_i(lsu_req_addr),
    .lsu_req_wen_i(lsu_req_wen), .lsu_req_wdata_i(lsu_req_wdata), .lsu_req_wmask_i(lsu_req_wmask),
    .lsu_rsp_valid_o(lsu_rsp_valid), .lsu_rsp_ready_i(lsu_rsp_ready), .lsu_rsp_data_o(lsu_rsp_data),
    .lsu_rsp_err_o(lsu_rsp_err),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
    .mem_req_wen_o(mem_req_wen), .mem_req_wdata_o(mem_req_wdata), .mem_req_wmask_o(mem_req_wmask),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready), .mem_rsp_data_i(mem_rsp_data)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Zero-wait memory: call while the arbiter is in REQ; returns in RSP.
  task automatic mem_zero_wait(input logic [63:0] data);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    lsu_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    tick(); tick();

    // Reset state
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    chk("rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    chk("rst_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
    chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_mem_rsp_ready", 64'(mem_rsp_ready), 64'd1);
    rst = 1'b0;
    tick();

    // IFU only, zero-wait memory, then response backpressure
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    #1;
    chk("t1_ifu_req_ready", 64'(ifu_req_ready), 64'd1);
    chk("t1_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
    tick();
    ifu_req_valid = 0;
    chk("t1_mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("t1_mem_req_addr", 64'(mem_req_addr), 64'h8000_0000);
    chk("t1_mem_req_wen", 64'(mem_req_wen), 64'd0);
    chk("t1_mem_req_wmask", 64'(mem_req_wmask), 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("t1_wait_no_rsp", 64'(ifu_rsp_valid), 64'd0);
    chk("t1_wait_mem_req_valid", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0013_0000_0297;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    chk("t1_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    chk("t1_ifu_rsp_data", ifu_rsp_data, 64'h0000_0013_0000_0297);
    chk("t1_ifu_rsp_err", 64'(ifu_rsp_err), 64'd0);
    chk("t1_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
      chk("bp_ifu_rsp_data", ifu_rsp_data, 64'h0000_0013_0000_0297);
      chk("bp_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
      tick();
    end
    lsu_req_valid = 0;
    ifu_rsp_ready = 1;
    tick();
    ifu_rsp_ready = 0;
    chk("t1_ifu_rsp_done", 64'(ifu_rsp_valid), 64'd0);

    // Simultaneous requests from reset: LSU, IFU, LSU
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 0;
    #1;
    chk("rr1_lsu_ready", 64'(lsu_req_ready), 64'd1);
    chk("rr1_ifu_ready", 64'(ifu_req_ready), 64'd0);
    tick();
    chk("rr1_mem_addr", 64'(mem_req_addr), 64'h8000_2000);
    mem_zero_wait(64'h1111_2222_3333_4444);
    chk("rr1_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
    chk("rr1_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    chk("rr1_lsu_rsp_data", lsu_rsp_data, 64'h1111_2222_3333_4444);
    lsu_rsp_ready = 1;
    tick();
    lsu_rsp_ready = 0;
    chk("rr2_ifu_ready", 64'(ifu_req_ready), 64'd1);
    chk("rr2_lsu_ready", 64'(lsu_req_ready), 64'd0);
    tick();
    chk("rr2_mem_addr", 64'(mem_req_addr), 64'h8000_0040);
    mem_zero_wait(64'h5555_6666_7777_8888);
    chk("rr2_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    chk("rr2_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    ifu_rsp_ready = 1;
    tick();
    ifu_rsp_ready = 0;
    chk("rr3_lsu_ready", 64'(lsu_req_ready), 64'd1);
    chk("rr3_ifu_ready", 64'(ifu_req_ready), 64'd0);

    // LSU write with three memory stall cycles
    ifu_req_valid = 0;
    lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 64'hDEAD_BEEF_CAFE_F00D; lsu_req_wmask = 8'h0F;
    tick();
    lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_mem_req_valid", 64'(mem_req_valid), 64'd1);
      chk("wr_mem_req_addr", 64'(mem_req_addr), 64'h8000_1000);
      chk("wr_mem_req_wen", 64'(mem_req_wen), 64'd1);
      chk("wr_mem_req_wdata", mem_req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("wr_mem_req_wmask", 64'(mem_req_wmask), 64'h0F);
      if (i < 3) tick();
    end
    mem_zero_wait(64'h0000_0000_0000_0ACE);
    chk("wr_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
    chk("wr_lsu_rsp_err", 64'(lsu_rsp_err), 64'd0);
    lsu_rsp_ready = 1;
    tick();
    lsu_rsp_ready = 0;

    // Timeout: no memory response, then a late stray response
    ifu_req_valid = 1; ifu_req_addr = 32'h0000_0100;
    tick();
    ifu_req_valid = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_no_rsp", 64'(ifu_rsp_valid), 64'd0);
      tick();
    end
    chk("to_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    chk("to_ifu_rsp_err", 64'(ifu_rsp_err), 64'd1);
    chk("to_ifu_rsp_data", ifu_rsp_data, 64'd0);
    chk("to_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    ifu_rsp_ready = 1;
    tick();
    ifu_rsp_ready = 0;
    mem_rsp_valid = 1; mem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      chk("late_mem_rsp_ready", 64'(mem_rsp_ready), 64'd1);
      tick();
      chk("late_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
      chk("late_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
      chk("late_mem_req_valid", 64'(mem_req_valid), 64'd0);
    end
    mem_rsp_valid = 0; mem_rsp_data = '0;

    // Asynchronous reset while in WAIT, then a normal transaction
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_0200; lsu_req_wen = 0;
    tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    chk("ar_pre_addr", 64'(mem_req_addr), 64'h0000_0200);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("ar_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    chk("ar_mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("ar_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("ar_post_lsu_ready", 64'(lsu_req_ready), 64'd1);
    tick();
    lsu_req_valid = 0;
    chk("ar_post_mem_valid", 64'(mem_req_valid), 64'd1);
    chk("ar_post_mem_addr", 64'(mem_req_addr), 64'h0000_0200);
    mem_zero_wait(64'h0123_4567_89AB_CDEF);
    chk("ar_post_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd1);
    chk("ar_post_lsu_rsp_data", lsu_rsp_data, 64'h0123_4567_89AB_CDEF);
    lsu_rsp_ready = 1;
    tick();
    lsu_rsp_ready = 0;
    chk("ar_post_done", 64'(lsu_rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
